i2s_tx_ctrl: RTL and testbench

- Sequences the I2S transmit datapath from the prescaler configured over the Wishbone register interface.
- Divides wb_clk down to the serial bit clock (SCK) and generates word select (WS).
- Serialises stereo sample frames taken from a single-entry holding buffer with a valid/ready handshake.
- Flags and counts underruns when no sample is available at a frame boundary.

---
 rtl/i2s_tx_ctrl.sv | 147 ++++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_ctrl
// Description : I2S transmit sequencer: SCK/WS generation from a programmable
//               prescaler, single-entry sample buffer and underrun accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_ctrl #(
    parameter int WB_DW    = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                  wb_clk,
    input  logic                  rst,
    input  logic [WB_DW-1:0]      prescaler,
    input  logic [2*SAMPLE_W-1:0] sample_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  i2s_sck_o,
    output logic                  i2s_ws_o,
    output logic                  i2s_sd_o,
    output logic                  frame_o,
    output logic                  underrun_o,
    output logic [15:0]           underrun_cnt_o
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int BCW     = $clog2(FRAME_W);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_W - 1);
    localparam logic [BCW-1:0] HALF     = BCW'(SAMPLE_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WB_DW-1:0]     div_cnt;
    logic                 sck;
    logic                 ws;
    logic                 sd;
    logic                 frame;
    logic                 underrun;
    logic [15:0]          underrun_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [FRAME_W-1:0]   shifter;
    logic [FRAME_W-1:0]   hold;
    logic                 hold_valid;

    logic                 run;
    logic                 wrap;
    logic                 fall;
    logic                 load;
    logic                 accept;
    logic [BCW-1:0]       bit_nxt;
    logic [BCW-1:0]       sd_idx;
    logic [BCW-1:0]       ws_idx;
    logic [FRAME_W-1:0]   frame_val;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (prescaler != '0) state_nxt = ST_RUN;
            ST_RUN:  if (prescaler == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The datapath follows the next state so a disable takes effect on the very next edge.
    always_comb begin
        run       = (state_nxt == ST_RUN);
        wrap      = run && (div_cnt >= (prescaler - WB_DW'(1)));
        fall      = wrap && sck;
        bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        load      = fall && (bit_nxt == '0);
        frame_val = load ? (hold_valid ? hold : '0) : shifter;
        sd_idx    = BIT_LAST - bit_nxt;
        ws_idx    = (bit_nxt == BIT_LAST) ? '0 : bit_nxt + 1'b1;
        accept    = sample_valid_i && !hold_valid;
    end

    always_ff @(posedge wb_clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            sck          <= 1'b0;
            ws           <= 1'b0;
            sd           <= 1'b0;
            frame        <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            bit_cnt      <= BIT_LAST;
            shifter      <= '0;
            hold         <= '0;
            hold_valid   <= 1'b0;
        end else begin
            state    <= state_nxt;
            frame    <= 1'b0;
            underrun <= 1'b0;

            if (!run) begin
                div_cnt <= '0;
                sck     <= 1'b0;
                ws      <= 1'b0;
                sd      <= 1'b0;
                bit_cnt <= BIT_LAST;
            end else if (wrap) begin
                div_cnt <= '0;
                sck     <= ~sck;
                if (fall) begin
                    bit_cnt <= bit_nxt;
                    sd      <= frame_val[sd_idx];
                    ws      <= (ws_idx >= HALF);
                    if (load) begin
                        shifter <= frame_val;
                        frame   <= 1'b1;
                        if (!hold_valid) begin
                            underrun <= 1'b1;
                            if (underrun_cnt != 16'hFFFF)
                                underrun_cnt <= underrun_cnt + 1'b1;
                        end
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // A load that finds the buffer empty still lets a same-cycle accept fill it.
            if (load && hold_valid) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold       <= sample_i;
                hold_valid <= 1'b1;
            end
        end
    end

    assign sample_ready_o = !hold_valid;
    assign i2s_sck_o      = sck;
    assign i2s_ws_o       = ws;
    assign i2s_sd_o       = sd;
    assign frame_o        = frame;
    assign underrun_o     = underrun;
    assign underrun_cnt_o = underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_ctrl
// Description : Scoreboard bench for i2s_tx_ctrl with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_ctrl;

    localparam int SW = 16;
    localparam int FW = 2 * SW;

    logic          wb_clk         = 1'b0;
    logic          rst            = 1'b1;
    logic [31:0]   prescaler      = '0;
    logic [FW-1:0] sample_i       = '0;
    logic          sample_valid_i = 1'b0;
    logic          sample_ready_o;
    logic          i2s_sck_o;
    logic          i2s_ws_o;
    logic          i2s_sd_o;
    logic          frame_o;
    logic          underrun_o;
    logic [15:0]   underrun_cnt_o;

    i2s_tx_ctrl #(.WB_DW(32), .SAMPLE_W(SW)) dut (
        .wb_clk         (wb_clk),
        .rst            (rst),
        .prescaler      (prescaler),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .i2s_sck_o      (i2s_sck_o),
        .i2s_ws_o       (i2s_ws_o),
        .i2s_sd_o       (i2s_sd_o),
        .frame_o        (frame_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o)
    );

    always #5 wb_clk = ~wb_clk;

    int errors = 0;
    int checks = 0;
    int ovr_seq = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [FW-1:0] mq[$];
    logic [FW-1:0] cur      = '0;
    logic [FW-1:0] expf;
    logic [FW-1:0] pend_smp = '0;
    logic          eu;
    logic          prev_sck  = 1'b0;
    logic          pend_rst  = 1'b1;
    logic          pend_idle = 1'b1;
    logic          pend_acc  = 1'b0;
    logic          tog;
    logic          fall;
    int mcnt = 0, bit_i = -1, gap = 0, p_first = 0, p_cur = 0;
    int chg_n = 0, k_chg = 0, exp_gap = 0, ovr_seen = 0, pend_p = 0;

    always @(negedge wb_clk) begin
        if (ovr_seq != ovr_seen) begin
            ovr_seen = ovr_seq;
            mcnt     = 65533;
        end
        if (pend_rst) begin
            mq.delete();
            mcnt  = 0;
            bit_i = -1;
            gap   = 0;
            chk("rst_sck", i2s_sck_o, 0);
            chk("rst_ws", i2s_ws_o, 0);
            chk("rst_sd", i2s_sd_o, 0);
            chk("rst_frame", frame_o, 0);
            chk("rst_underrun", underrun_o, 0);
            chk("rst_cnt", underrun_cnt_o, 0);
            chk("rst_ready", sample_ready_o, 1);
        end else if (pend_idle) begin
            bit_i = -1;
            gap   = 0;
            chk("idle_sck", i2s_sck_o, 0);
            chk("idle_ws", i2s_ws_o, 0);
            chk("idle_sd", i2s_sd_o, 0);
            chk("idle_frame", frame_o, 0);
            chk("idle_underrun", underrun_o, 0);
            chk("idle_cnt", underrun_cnt_o, mcnt);
            if (pend_acc) mq.push_back(pend_smp);
            chk("ready", sample_ready_o, (mq.size() == 0));
        end else begin
            tog  = (i2s_sck_o != prev_sck);
            fall = tog && prev_sck;
            // SCK half period: the prescaler seen at each edge; a single change is honoured at once
            gap++;
            if (gap == 1) begin
                p_first = pend_p;
                p_cur   = pend_p;
                chg_n   = 0;
            end else if (pend_p != p_cur) begin
                chg_n++;
                k_chg = gap - 1;
                p_cur = pend_p;
            end
            exp_gap = (chg_n == 0) ? p_first : ((k_chg + 1 > p_cur) ? k_chg + 1 : p_cur);
            if (chg_n <= 1) begin
                if (tog)                 chk("sck_half_period", gap, exp_gap);
                else if (gap == exp_gap) chk("sck_toggle_due", tog, 1);
            end
            if (tog) gap = 0;

            if (frame_o || (fall && (bit_i == -1 || bit_i == FW - 1)))
                chk("frame_at_boundary", frame_o, (fall && (bit_i == -1 || bit_i == FW - 1)));
            if (frame_o) begin
                if (mq.size() > 0) begin
                    expf = mq.pop_front();
                    eu   = 1'b0;
                end else begin
                    expf = '0;
                    eu   = 1'b1;
                    if (mcnt < 65535) mcnt++;
                end
                chk("underrun_flag", underrun_o, eu);
                cur   = expf;
                bit_i = 0;
            end else begin
                chk("underrun_flag", underrun_o, 0);
                if (fall && bit_i >= 0) bit_i++;
            end
            if (fall && bit_i >= 0 && bit_i < FW) begin
                chk("sd_bit", i2s_sd_o, cur[FW-1-bit_i]);
                chk("ws", i2s_ws_o, (((bit_i + 1) % FW) >= SW));
            end
            chk("underrun_cnt", underrun_cnt_o, mcnt);
            if (pend_acc) mq.push_back(pend_smp);
            chk("ready", sample_ready_o, (mq.size() == 0));
        end
        prev_sck  = i2s_sck_o;
        pend_rst  = rst;
        pend_idle = (prescaler == 0);
        pend_acc  = sample_valid_i && sample_ready_o;
        pend_smp  = sample_i;
        pend_p    = int'(prescaler);
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    initial begin
        logic s;
        int   n;
        int   dur;
        int   prob;

        cycles(3);
        rst = 1'b0;

        // preload a known frame while idle, then run at prescaler 2
        sample_i = 32'hA5A5_0F0F;
        sample_valid_i = 1'b1;
        cycles(1);
        sample_valid_i = 1'b0;
        cycles(6);
        prescaler = 2;
        cycles(300);

        // continuous stream at the fastest rate
        sample_valid_i = 1'b1;
        prescaler = 1;
        for (int i = 0; i < 400; i++) begin
            sample_i = $urandom;
            cycles(1);
        end
        sample_valid_i = 1'b0;

        // starvation, then saturation of the underrun counter
        prescaler = 3;
        cycles(4 * 192 + 20);
        prescaler = 0;
        cycles(2);
        force dut.underrun_cnt = 16'hFFFD;
        ovr_seq++;
        #1 release dut.underrun_cnt;
        cycles(1);
        prescaler = 3;
        cycles(3 * 192 + 30);

        // prescaler shrink mid half-period
        prescaler = 0;
        sample_i = $urandom;
        sample_valid_i = 1'b1;
        cycles(1);
        sample_valid_i = 1'b0;
        prescaler = 8;
        cycles(40);
        s = i2s_sck_o;
        n = 0;
        while (i2s_sck_o == s && n < 64) begin
            cycles(1);
            n++;
        end
        cycles(5);
        prescaler = 2;
        sample_i = $urandom;
        sample_valid_i = 1'b1;
        cycles(1);
        sample_valid_i = 1'b0;
        cycles(20);

        // disable mid-frame with a full buffer, then re-enable
        prescaler = 0;
        cycles(10);
        prescaler = 2;
        cycles(200);

        // reset mid-frame with the buffer occupied
        n = 0;
        while (!frame_o && n < 300) begin
            cycles(1);
            n++;
        end
        sample_i = $urandom;
        sample_valid_i = 1'b1;
        cycles(1);
        sample_valid_i = 1'b0;
        cycles(10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(50);

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            dur  = $urandom_range(300, 60);
            prob = $urandom_range(100, 0);
            prescaler = $urandom_range(4, 0);
            for (int c = 0; c < dur; c++) begin
                sample_valid_i = ($urandom_range(99, 0) < prob);
                sample_i = $urandom;
                rst = (c == dur / 2) && (it % 5 == 4);
                cycles(1);
            end
        end
        rst = 1'b0;
        sample_valid_i = 1'b0;
        prescaler = 0;
        cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
